dm_responder: RTL and testbench

- Data-memory responder (slave end) for the CPU's load/store port.
- Accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Performs word, half or byte access with lane merging on stores and sign extension on loads.
- Returns data or an error over a valid/ready response channel. It replaces the zero-latency combinational data memory once the core moves to a handshaked memory interface.

---
 rtl/dm_responder.sv | 179 +++++++++++++++++
 tb/tb_dm_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one load/store at a time over valid/ready,
// waits LATENCY cycles, commits to a word-wide memory with byte-lane merging,
// and returns sign-extended load data or an error over a valid/ready response.
module dm_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              accept, commit;

    logic              r_write;
    logic [1:0]        r_type;
    logic [31:0]       r_addr, r_wdata, r_pc;

    // fields seen at commit: live inputs when committing straight from IDLE
    logic              c_write;
    logic [1:0]        c_type;
    logic [31:0]       c_addr, c_wdata, c_pc;

    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]       old_word, merged, load_data;
    logic              err;

    logic [31:0]       mem [DEPTH];

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state, handshake outputs and commit strobe
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // select request fields that apply on the commit edge
    always_comb begin
        if (state == IDLE) begin
            c_write = req_write;
            c_type  = req_type;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_pc    = req_pc;
        end else begin
            c_write = r_write;
            c_type  = r_type;
            c_addr  = r_addr;
            c_wdata = r_wdata;
            c_pc    = r_pc;
        end
    end

    // error decode, lane merge for stores, sign extension for loads
    always_comb begin
        idx       = c_addr[ADDR_WIDTH+1:2];
        old_word  = mem[idx];
        merged    = old_word;
        load_data = old_word;
        err       = (c_addr >> (ADDR_WIDTH + 2)) != 32'd0;
        case (c_type)
            2'b00: begin
                if (c_addr[1:0] != 2'b00) err = 1'b1;
                merged = c_wdata;
            end
            2'b01: begin
                if (c_addr[0]) err = 1'b1;
                merged[{c_addr[1], 4'b0000} +: 16] = c_wdata[15:0];
                load_data = {{16{old_word[{c_addr[1], 4'b1111}]}},
                             old_word[{c_addr[1], 4'b0000} +: 16]};
            end
            2'b10: begin
                merged[{c_addr[1:0], 3'b000} +: 8] = c_wdata[7:0];
                load_data = {{24{old_word[{c_addr[1:0], 3'b111}]}},
                             old_word[{c_addr[1:0], 3'b000} +: 8]};
            end
            default: err = 1'b1;
        endcase
    end

    // request latch, wait counter and registered response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            r_write    <= 1'b0;
            r_type     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_pc       <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                r_write <= req_write;
                r_type  <= req_type;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_pc    <= req_pc;
                cnt     <= 4'(LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                resp_err   <= err;
                resp_rdata <= (err || c_write) ? 32'd0 : load_data;
            end else if (state == RESP && resp_ready) begin
                resp_err   <= 1'b0;
                resp_rdata <= '0;
            end
        end
    end

    // memory array: cleared by reset, written only by error-free store commits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit && c_write && !err) begin
            mem[idx] <= merged;
        end
    end

`ifndef SYNTHESIS
    // store trace for comparison against the reference core log
    always_ff @(posedge clk) begin
        if (reset && commit && c_write && !err)
            $display("@%h: *%h <= %h", c_pc, {c_addr[31:2], 2'b00}, merged);
    end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a LATENCY=2 instance for function and
// back-pressure, a LATENCY=0 instance for back-to-back throughput.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_type;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    logic        z_req_valid, z_req_ready, z_req_write;
    logic [1:0]  z_req_type;
    logic [31:0] z_req_addr, z_req_wdata, z_req_pc;
    logic        z_resp_valid, z_resp_ready, z_resp_err;
    logic [31:0] z_resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    dm_responder #(.ADDR_WIDTH(12), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_pc(req_pc), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dm_responder #(.ADDR_WIDTH(12), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_type(z_req_type), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .req_pc(z_req_pc), .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // wait for resp_valid (sampled at negedges), return cycles since acceptance
    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 40);
    endtask

    // one full transaction on the LATENCY=2 instance
    task automatic txn(input string tag, input logic w, input logic [1:0] t,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
        int lat;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_type  = t;
        req_addr  = a;
        req_wdata = d;
        req_pc    = 32'h100 + a;
        chk({tag, "_acc"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h0BAD_0BAD;
        req_type  = 2'b11;
        wait_resp(lat);
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          nresp;

        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_type = 2'b00;
        req_addr = '0; req_wdata = '0; req_pc = '0; resp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_type = 2'b00;
        z_req_addr = '0; z_req_wdata = '0; z_req_pc = '0; z_resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready",  {31'd0, req_ready},  32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata",      resp_rdata,          32'd0);
        chk("rst_err",        {31'd0, resp_err},   32'd0);
        reset = 1'b1;

        txn("st_w", 1'b1, 2'b00, 32'h10, 32'h1234_5678, rd, er);
        chk("st_w_err", {31'd0, er}, 32'd0);
        chk("st_w_rd",  rd, 32'd0);

        txn("st_b", 1'b1, 2'b10, 32'h11, 32'h5555_55AB, rd, er);
        chk("st_b_err", {31'd0, er}, 32'd0);
        txn("ld_w", 1'b0, 2'b00, 32'h10, 32'h0, rd, er);
        chk("ld_w_rd", rd, 32'h1234_AB78);
        txn("ld_b", 1'b0, 2'b10, 32'h11, 32'h0, rd, er);
        chk("ld_b_rd", rd, 32'hFFFF_FFAB);
        txn("ld_h", 1'b0, 2'b01, 32'h12, 32'h0, rd, er);
        chk("ld_h_rd", rd, 32'h0000_1234);

        txn("ld_h_mis", 1'b0, 2'b01, 32'h13, 32'h0, rd, er);
        chk("ld_h_mis_err", {31'd0, er}, 32'd1);
        chk("ld_h_mis_rd",  rd, 32'd0);
        txn("st_oor", 1'b1, 2'b00, 32'h0001_0000, 32'hCAFE_F00D, rd, er);
        chk("st_oor_err", {31'd0, er}, 32'd1);
        txn("ld_alias", 1'b0, 2'b00, 32'h0, 32'h0, rd, er);
        chk("ld_alias_rd", rd, 32'd0);
        txn("ld_t3", 1'b0, 2'b11, 32'h10, 32'h0, rd, er);
        chk("ld_t3_err", {31'd0, er}, 32'd1);
        chk("ld_t3_rd",  rd, 32'd0);
        txn("st_w_mis", 1'b1, 2'b00, 32'h12, 32'hFFFF_FFFF, rd, er);
        chk("st_w_mis_err", {31'd0, er}, 32'd1);
        txn("ld_w2", 1'b0, 2'b00, 32'h10, 32'h0, rd, er);
        chk("ld_w2_rd", rd, 32'h1234_AB78);

        txn("st_h", 1'b1, 2'b01, 32'h16, 32'hAAAA_8001, rd, er);
        chk("st_h_err", {31'd0, er}, 32'd0);
        txn("ld_h2", 1'b0, 2'b01, 32'h16, 32'h0, rd, er);
        chk("ld_h2_rd", rd, 32'hFFFF_8001);
        txn("ld_b2", 1'b0, 2'b10, 32'h17, 32'h0, rd, er);
        chk("ld_b2_rd", rd, 32'hFFFF_FF80);
        txn("ld_w3", 1'b0, 2'b00, 32'h14, 32'h0, rd, er);
        chk("ld_w3_rd", rd, 32'h8001_0000);
        txn("ld_b3", 1'b0, 2'b10, 32'h14, 32'h0, rd, er);
        chk("ld_b3_rd", rd, 32'd0);

        // back-pressure with a second request held pending
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_type = 2'b00; req_addr = 32'h10;
        @(posedge clk);
        #1;
        req_type = 2'b10; req_addr = 32'h11;
        wait_resp(lat);
        chk("bp_lat", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", {31'd0, resp_valid}, 32'd1);
            chk("bp_rd",  resp_rdata, 32'h1234_AB78);
            chk("bp_rdy", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_rdy", {31'd0, req_ready},  32'd1);
        chk("bp_idle_vld", {31'd0, resp_valid}, 32'd0);
        chk("bp_idle_rd",  resp_rdata, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_resp(lat);
        chk("bp2_lat", 32'(lat), 32'd3);
        chk("bp2_rd",  resp_rdata, 32'hFFFF_FFAB);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;

        // LATENCY=0: requests held back-to-back complete every two cycles
        @(negedge clk);
        z_req_valid = 1'b1; z_req_write = 1'b1; z_req_type = 2'b00;
        z_req_addr = 32'h40; z_req_wdata = 32'h0000_0077; z_resp_ready = 1'b1;
        nresp = 0;
        for (int i = 1; i <= 10; i++) begin
            chk("b2b_vld", {31'd0, z_resp_valid}, {31'd0, (i % 2 == 0)});
            if (z_resp_valid) begin
                nresp++;
                chk("b2b_rd", z_resp_rdata, 32'd0);
            end
            @(posedge clk);
            @(negedge clk);
        end
        z_req_valid = 1'b0;
        chk("b2b_count", 32'(nresp), 32'd5);
        @(negedge clk);
        z_req_valid = 1'b1; z_req_write = 1'b0;
        @(posedge clk);
        #1;
        z_req_valid = 1'b0;
        @(negedge clk);
        chk("z_ld_vld", {31'd0, z_resp_valid}, 32'd1);
        chk("z_ld_rd",  z_resp_rdata, 32'h0000_0077);
        @(posedge clk);
        #1;
        z_resp_ready = 1'b0;

        // reset while a store waits: dropped, memory cleared
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_type = 2'b00;
        req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("wait_rdy", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("arst_rdy",  {31'd0, req_ready},  32'd1);
        chk("arst_vld",  {31'd0, resp_valid}, 32'd0);
        chk("arst_rd",   resp_rdata,          32'd0);
        chk("arst_err",  {31'd0, resp_err},   32'd0);
        @(negedge clk);
        reset = 1'b1;
        txn("ld_20", 1'b0, 2'b00, 32'h20, 32'h0, rd, er);
        chk("ld_20_rd",  rd, 32'd0);
        chk("ld_20_err", {31'd0, er}, 32'd0);
        txn("ld_10", 1'b0, 2'b00, 32'h10, 32'h0, rd, er);
        chk("ld_10_rd",  rd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
